// File: rtl/cyclic_decoder_seq_pkg.sv
// cyclic_code_pkg: FSM state type and GF(2) polynomial helper shared by the cyclic decoder
package cyclic_code_pkg;
  localparam int MAXR = 32;
  typedef enum logic [1:0] {IDLE, CALC, TRAP, DONE} cdec_state_t;
  // (p * x) mod g for a degree-r generator; g carries only the low r coefficients
  function automatic logic [MAXR-1:0] gf2_mulx_mod(input logic [MAXR-1:0] p, input logic [MAXR-1:0] g, input int r);
    logic [MAXR-1:0] m;
    m = (MAXR'(1) << r) - MAXR'(1);
    return ((p << 1) ^ (p[$clog2(MAXR)'(r - 1)] ? g : '0)) & m;
  endfunction
endpackage

// File: rtl/cyclic_decoder_seq_if.sv
// cyclic_decoder_seq_if: codeword-in / result-out valid-ready bundle of the cyclic decoder
interface cyclic_decoder_seq_if #(parameter int N = 15, parameter int K = 7);
  localparam int R = N - K;
  logic         i_Valid;
  logic         o_Ready;
  logic [N-1:0] i_CodeWord;
  logic         o_Valid;
  logic         i_Ready;
  logic [K-1:0] o_DecodWord;
  logic [R-1:0] o_Syndrome;
  logic         o_ErrorC;
  logic         o_ErrorD;
  modport slave (input i_Valid, i_CodeWord, i_Ready, output o_Ready, o_Valid, o_DecodWord, o_Syndrome, o_ErrorC, o_ErrorD);
  modport master (output i_Valid, i_CodeWord, i_Ready, input o_Ready, o_Valid, o_DecodWord, o_Syndrome, o_ErrorC, o_ErrorD);
endinterface

// File: rtl/cyclic_decoder_seq_lfsr.sv
// cyclic_syndrome_lfsr: bit-serial remainder of the incoming bit stream modulo GEN_POLY
module cyclic_syndrome_lfsr
  import cyclic_code_pkg::*;
#(
  parameter int         R        = 8,
  parameter logic [R:0] GEN_POLY = 9'b111010001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [R-1:0] syn,
  output logic [R-1:0] syn_nxt
);
  logic [R-1:0] syn_q, syn_d;
  always_comb begin
    syn_d = clear ? '0 : shift_en ? R'(gf2_mulx_mod(MAXR'(syn_q), MAXR'(GEN_POLY[R-1:0]), R)) ^ R'(bit_in) : syn_q;
  end
  always_ff @(posedge clk) begin
    syn_q <= rst ? '0 : syn_d;
  end
  assign syn     = syn_q;
  assign syn_nxt = syn_d;
endmodule

// File: rtl/cyclic_decoder_seq.sv
// cyclic_decoder_seq: sequential (N,K) cyclic decoder with serial syndrome and single-bit error trapping
module cyclic_decoder_seq
  import cyclic_code_pkg::*;
#(
  parameter int           N        = 15,
  parameter int           K        = 7,
  parameter logic [N-K:0] GEN_POLY = 9'b111010001
) (
  input logic            i_Clk,
  input logic            i_Rst,
  cyclic_decoder_seq_if.slave bus
);
  localparam int R = N - K;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (N <= K || K < 1 || R < 2 || R > MAXR || !GEN_POLY[R] || !GEN_POLY[0]) begin : g_bad_param
    $error("cyclic_decoder_seq: illegal N/K/GEN_POLY combination");
  end
  cdec_state_t   state_q, state_d;
  logic [N-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [R-1:0]  p_q, p_d, syn_q, syn_d, lfsr_syn, lfsr_nxt;
  logic [K-1:0]  decod_q, decod_d;
  logic          valid_q, valid_d, errc_q, errc_d, errd_q, errd_d;
  cyclic_syndrome_lfsr #(.R(R), .GEN_POLY(GEN_POLY)) u_lfsr (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .clear   (state_q == IDLE && bus.i_Valid),
    .shift_en(state_q == CALC),
    .bit_in  (buf_q[LAST - cnt_q]),
    .syn     (lfsr_syn),
    .syn_nxt (lfsr_nxt)
  );
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    syn_d   = syn_q;
    valid_d = valid_q;
    errc_d  = errc_q;
    errd_d  = errd_q;
    case (state_q)
      IDLE: if (bus.i_Valid) begin
        buf_d   = bus.i_CodeWord;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          syn_d   = lfsr_nxt;
          cnt_d   = '0;
          p_d     = R'(1);
          errc_d  = 1'b0;
          errd_d  = 1'b0;
          valid_d = lfsr_nxt == '0;
          state_d = lfsr_nxt == '0 ? DONE : TRAP;
        end
      end
      // p tracks x^cnt mod g; the first position whose syndrome matches is the flipped bit
      TRAP: if (p_q == lfsr_syn) begin
        buf_d[cnt_q] = ~buf_q[cnt_q];
        errc_d  = 1'b1;
        valid_d = 1'b1;
        state_d = DONE;
      end else if (cnt_q == LAST) begin
        errd_d  = 1'b1;
        valid_d = 1'b1;
        state_d = DONE;
      end else begin
        p_d   = R'(gf2_mulx_mod(MAXR'(p_q), MAXR'(GEN_POLY[R-1:0]), R));
        cnt_d = cnt_q + 1'b1;
      end
      DONE: if (bus.i_Ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    decod_d = (state_d == DONE && state_q != DONE) ? buf_d[N-1:R] : decod_q;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      syn_q   <= '0;
      decod_q <= '0;
      valid_q <= 1'b0;
      errc_q  <= 1'b0;
      errd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      syn_q   <= syn_d;
      decod_q <= decod_d;
      valid_q <= valid_d;
      errc_q  <= errc_d;
      errd_q  <= errd_d;
    end
  end
  assign bus.o_Ready     = state_q == IDLE && !i_Rst;
  assign bus.o_Valid     = valid_q;
  assign bus.o_DecodWord = decod_q;
  assign bus.o_Syndrome  = syn_q;
  assign bus.o_ErrorC    = errc_q;
  assign bus.o_ErrorD    = errd_q;
endmodule

// File: tb/tb_cyclic_decoder_seq.sv
// tb_cyclic_decoder_seq: scoreboard bench for the cyclic decoder (directed vectors, backpressure, reset, random)
module tb_cyclic_decoder_seq;
  localparam int N = 15;
  localparam int K = 7;
  localparam int R = N - K;
  localparam logic [R:0] G = 9'b111010001;
  typedef struct {
    logic [R-1:0] syn;
    logic [K-1:0] dec;
    logic         c;
    logic         d;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  cyclic_decoder_seq_if #(.N(N), .K(K)) bus ();
  cyclic_decoder_seq #(.N(N), .K(K), .GEN_POLY(G)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [R-1:0] rem(input logic [N-1:0] w);
    for (int i = N - 1; i >= R; i--)
      if (w[i]) w = w ^ (N'(G) << (i - R));
    return w[R-1:0];
  endfunction
  function automatic exp_t model(input logic [N-1:0] w);
    exp_t e;
    e.syn = rem(w);
    e.c = 1'b0;
    e.d = 1'b0;
    e.lat = N + 1;
    if (e.syn != '0) begin
      e.d = 1'b1;
      e.lat = 2 * N + 1;
      for (int j = 0; j < N; j++)
        if (rem(N'(1) << j) == e.syn) begin
          w = w ^ (N'(1) << j);
          e.c = 1'b1;
          e.d = 1'b0;
          e.lat = N + 2 + j;
          break;
        end
    end
    e.dec = w[N-1:R];
    return e;
  endfunction
  task automatic accept(input logic [N-1:0] w, output bit ok);
    ok = 1'b0;
    bus.i_Valid = 1'b1;
    bus.i_CodeWord = w;
    for (int i = 0; i < 50; i++) begin
      if (bus.o_Ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.i_Valid = 1'b0;
    bus.i_CodeWord = N'($urandom);
  endtask
  task automatic run(input logic [N-1:0] w, input exp_t e, input int hold);
    bit ok;
    int lat;
    exp_t x;
    sb.push_back(e);
    accept(w, ok);
    chk("accept", 32'(ok), 1);
    lat = 1;
    while (ok && !bus.o_Valid && lat < 3 * N) begin
      @(negedge clk);
      lat++;
    end
    x = sb.pop_front();
    if (!ok) return;
    chk("o_valid", 32'(bus.o_Valid), 1);
    chk("latency", 32'(lat), 32'(x.lat));
    chk("syndrome", 32'(bus.o_Syndrome), 32'(x.syn));
    chk("decod", 32'(bus.o_DecodWord), 32'(x.dec));
    chk("error_c", 32'(bus.o_ErrorC), 32'(x.c));
    chk("error_d", 32'(bus.o_ErrorD), 32'(x.d));
    chk("flags_excl", 32'(bus.o_ErrorC & bus.o_ErrorD), 0);
    bus.i_Valid = hold > 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.o_Valid), 1);
      chk("bp_ready", 32'(bus.o_Ready), 0);
      chk("bp_decod", 32'(bus.o_DecodWord), 32'(x.dec));
      chk("bp_syn", 32'(bus.o_Syndrome), 32'(x.syn));
      chk("bp_flags", 32'({bus.o_ErrorC, bus.o_ErrorD}), 32'({x.c, x.d}));
    end
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b1;
    @(negedge clk);
    bus.i_Ready = 1'b0;
    chk("valid_drop", 32'(bus.o_Valid), 0);
    chk("ready_back", 32'(bus.o_Ready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok, seen;
    logic [K-1:0] msg;
    logic [N-1:0] w;
    bus.i_Valid = 1'b0;
    bus.i_Ready = 1'b0;
    bus.i_CodeWord = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_Ready), 0);
    chk("rst_outs", 32'({bus.o_Valid, bus.o_DecodWord, bus.o_Syndrome, bus.o_ErrorC, bus.o_ErrorD}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.o_Ready), 1);
    run(15'h0000, '{8'h00, 7'h00, 1'b0, 1'b0, 16}, 0);
    run(15'h7440, '{8'h00, 7'h74, 1'b0, 1'b0, 16}, 0);
    run(15'h0001, '{8'h01, 7'h00, 1'b1, 1'b0, 17}, 0);
    run(15'h4000, '{8'hE8, 7'h00, 1'b1, 1'b0, 31}, 0);
    run(15'h0100, '{8'hD1, 7'h00, 1'b1, 1'b0, 25}, 5);
    run(15'h0003, '{8'h03, 7'h00, 1'b0, 1'b1, 31}, 0);
    accept(15'h7441, ok);
    chk("rst_accept", 32'(ok), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.o_Ready), 0);
    chk("midrst_outs", 32'({bus.o_Valid, bus.o_DecodWord, bus.o_Syndrome, bus.o_ErrorC, bus.o_ErrorD}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", 32'(bus.o_Ready), 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.o_Valid;
    end
    chk("midrst_no_valid", 32'(seen), 0);
    run(15'h0001, '{8'h01, 7'h00, 1'b1, 1'b0, 17}, 0);
    for (int i = 0; i < 10; i++) begin
      msg = K'($urandom);
      w = {msg, {R{1'b0}}};
      w = w ^ N'(rem(w));
      if (i % 3 == 1) w = w ^ (N'(1) << $urandom_range(N - 1));
      if (i % 3 == 2) w = N'($urandom);
      run(w, model(w), i % 2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
